// File: rtl/spi_bar_reg_ctrl_if.sv
// Bus bundle between the SPI pins / timing generator and the bar register
// controller. The controller takes the slave side; the pin driver takes master.
interface spi_bar_reg_ctrl_if #(
  parameter int N_BARS = 15,
  parameter int DATA_W = 8
);
  logic                       spi_clk;
  logic                       spi_csel;
  logic                       spi_mosi;
  logic                       frame_start;
  logic [N_BARS*DATA_W-1:0]   bar_vals;
  logic                       pending;
  logic                       wr_strobe;
  logic                       err_addr;
  logic                       err_len;

  modport master (
    output spi_clk, spi_csel, spi_mosi, frame_start,
    input  bar_vals, pending, wr_strobe, err_addr, err_len
  );

  modport slave (
    input  spi_clk, spi_csel, spi_mosi, frame_start,
    output bar_vals, pending, wr_strobe, err_addr, err_len
  );
endinterface

// File: rtl/spi_bar_reg_ctrl.sv
// Frame-synchronised bar register controller: oversamples the SPI pins,
// assembles 16-bit {data, addr} packets into a shadow file and commits the
// shadow file to the live bar registers on frame_start only.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a synced chip-select rising edge
// SHIFT | packet framed; shifting mosi on each synced spi_clk rise
// CHECK | one cycle: validate length/address, write shadow or flag error
module spi_bar_reg_ctrl #(
  parameter int N_BARS      = 15,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic              CLOCK_50,
  input logic              reset,
  spi_bar_reg_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  localparam logic [7:0] ADDR_LIMIT = 8'(N_BARS);
  localparam logic [4:0] CNT_FULL   = 5'd16;
  localparam logic [4:0] CNT_SAT    = 5'd17;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] clk_sync, csel_sync, mosi_sync;
  logic                   clk_hist, csel_hist;
  logic                   clk_s, csel_s, mosi_s;
  logic                   clk_rise, csel_rise, csel_fall;

  logic [15:0]              shift_reg;
  logic [4:0]               bit_cnt;
  logic [N_BARS*DATA_W-1:0] shadow, live;
  logic                     pending_q, wr_strobe_q, err_addr_q, err_len_q;

  logic shift_clr, shift_en, wr_en, err_addr_n, err_len_n;
  logic [7:0] pkt_addr;

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign csel_s    = csel_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign clk_rise  = clk_s & ~clk_hist;
  assign csel_rise = csel_s & ~csel_hist;
  assign csel_fall = ~csel_s & csel_hist;
  assign pkt_addr  = shift_reg[7:0];

  // Pin synchronisers plus history flops; csel resets high so a chip select
  // already asserted when reset drops does not look like a new packet.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync  <= '0;
      csel_sync <= '1;
      mosi_sync <= '0;
      clk_hist  <= 1'b0;
      csel_hist <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      csel_sync <= {csel_sync[SYNC_STAGES-2:0], bus.spi_csel};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      clk_hist  <= clk_s;
      csel_hist <= csel_s;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and per-cycle control decode; a clock rise coinciding with
  // the csel fall is dropped so the packet length is judged as framed.
  always_comb begin
    next_state = state;
    shift_clr  = 1'b0;
    shift_en   = 1'b0;
    wr_en      = 1'b0;
    err_addr_n = 1'b0;
    err_len_n  = 1'b0;
    case (state)
      IDLE: begin
        if (csel_rise) begin
          next_state = SHIFT;
          shift_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (csel_fall)     next_state = CHECK;
        else if (clk_rise) shift_en   = 1'b1;
      end
      CHECK: begin
        next_state = IDLE;
        if (bit_cnt != CNT_FULL)         err_len_n  = 1'b1;
        else if (pkt_addr >= ADDR_LIMIT) err_addr_n = 1'b1;
        else                             wr_en      = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Shift register, shadow file, commit to live bars and registered pulses.
  // On a coincident commit and write, live takes the old shadow and the new
  // write stays pending for the following frame.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      shadow      <= '0;
      live        <= '0;
      pending_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      err_addr_q  <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      if (shift_clr) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (shift_en) begin
        shift_reg <= {mosi_s, shift_reg[15:1]};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
      end

      if (bus.frame_start && pending_q) live <= shadow;

      if (wr_en) begin
        for (int i = 0; i < N_BARS; i++) begin
          if (pkt_addr == 8'(i)) shadow[i*DATA_W +: DATA_W] <= DATA_W'(shift_reg[15:8]);
        end
        pending_q <= 1'b1;
      end else if (bus.frame_start) begin
        pending_q <= 1'b0;
      end

      wr_strobe_q <= wr_en;
      err_addr_q  <= err_addr_n;
      err_len_q   <= err_len_n;
    end
  end

  assign bus.bar_vals  = live;
  assign bus.pending   = pending_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.err_len   = err_len_q;

endmodule

// File: tb/tb_spi_bar_reg_ctrl.sv
// Directed bench for spi_bar_reg_ctrl: a packet-level model predicts the
// shadow/live files and pushes the expected pulse for every packet; a
// monitor pops and compares each pulse as the DUT produces it.
module tb_spi_bar_reg_ctrl;
  localparam int N_BARS = 15;
  localparam int DATA_W = 8;
  localparam logic [2:0] EXP_WR   = 3'b001;
  localparam logic [2:0] EXP_ADDR = 3'b010;
  localparam logic [2:0] EXP_LEN  = 3'b100;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  spi_bar_reg_ctrl_if #(.N_BARS(N_BARS), .DATA_W(DATA_W)) bus ();

  spi_bar_reg_ctrl #(.N_BARS(N_BARS), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] sb[$];
  logic [N_BARS*DATA_W-1:0] m_shadow = '0;
  logic [N_BARS*DATA_W-1:0] m_live   = '0;
  logic                     m_pending = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each pulse must match the next expected outcome; extra pulses hit an empty queue.
  always @(negedge CLOCK_50) begin
    if (!reset && (bus.wr_strobe || bus.err_addr || bus.err_len)) begin
      if (sb.size() == 0) check("sb_unexpected_pulse", {bus.err_len, bus.err_addr, bus.wr_strobe}, 3'b000);
      else check("sb_pulse", {bus.err_len, bus.err_addr, bus.wr_strobe}, sb.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic model_commit();
    if (m_pending) begin
      m_live    = m_shadow;
      m_pending = 1'b0;
    end
  endtask

  // Drive one framed packet of n bits (4 CLOCK_50 cycles per SPI phase);
  // optionally pulse frame_start in the cycle the DUT spends in CHECK.
  task automatic send_raw(input logic [31:0] bits, input int n, input bit fs_at_check,
                          input logic [2:0] code);
    sb.push_back(code);
    bus.spi_csel = 1'b1;
    cyc(4);
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = bits[i];
      cyc(4);
      bus.spi_clk = 1'b1;
      cyc(4);
      bus.spi_clk = 1'b0;
    end
    cyc(4);
    bus.spi_csel = 1'b0;
    if (fs_at_check) begin
      cyc(3);
      bus.frame_start = 1'b1;
      model_commit();
      cyc(1);
      bus.frame_start = 1'b0;
      cyc(6);
    end else begin
      cyc(10);
    end
    check("sb_drained", 128'(sb.size()), 128'd0);
  endtask

  task automatic send_pkt(input logic [7:0] addr, input logic [7:0] data, input bit fs_at_check);
    logic [2:0] code;
    code = (addr < 8'(N_BARS)) ? EXP_WR : EXP_ADDR;
    send_raw({16'h0, data, addr}, 16, fs_at_check, code);
    if (code == EXP_WR) begin
      m_shadow[addr*DATA_W +: DATA_W] = data;
      m_pending = 1'b1;
    end
  endtask

  task automatic pulse_frame();
    bus.frame_start = 1'b1;
    model_commit();
    cyc(1);
    bus.frame_start = 1'b0;
    cyc(2);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_bars"}, 128'(bus.bar_vals), 128'(m_live));
    check({tag, "_pending"}, 128'(bus.pending), 128'(m_pending));
  endtask

  initial begin
    logic [N_BARS*DATA_W-1:0] bars_snap;

    bus.spi_clk     = 1'b0;
    bus.spi_csel    = 1'b0;
    bus.spi_mosi    = 1'b0;
    bus.frame_start = 1'b0;
    reset = 1'b1;
    cyc(4);
    reset = 1'b0;
    cyc(3);
    check_state("reset");
    check("reset_pulses", {bus.err_len, bus.err_addr, bus.wr_strobe}, 3'b000);

    // Basic write: held in shadow until frame_start.
    send_pkt(8'h03, 8'hA5, 1'b0);
    check_state("wr3_before_frame");
    pulse_frame();
    check_state("wr3_after_frame");
    check("wr3_bar3", 128'(bus.bar_vals[3*DATA_W +: DATA_W]), 128'h00A5);

    // Out-of-range address.
    send_pkt(8'h0F, 8'h11, 1'b0);
    check_state("addr_err");
    pulse_frame();
    check_state("addr_err_frame");

    // Short and long packets.
    send_raw(32'h0000_0A07, 12, 1'b0, EXP_LEN);
    send_raw(32'h000F_1107, 20, 1'b0, EXP_LEN);
    check_state("len_err");
    pulse_frame();
    check_state("len_err_frame");

    // Last write wins, plus highest legal address.
    send_pkt(8'h07, 8'h10, 1'b0);
    send_pkt(8'h07, 8'h20, 1'b0);
    send_pkt(8'h0E, 8'hC3, 1'b0);
    pulse_frame();
    check_state("lww");
    check("lww_bar7", 128'(bus.bar_vals[7*DATA_W +: DATA_W]), 128'h0020);
    check("bar14", 128'(bus.bar_vals[14*DATA_W +: DATA_W]), 128'h00C3);

    // frame_start coincident with CHECK of a write.
    send_pkt(8'h02, 8'h66, 1'b0);
    send_pkt(8'h01, 8'h55, 1'b1);
    check_state("coinc");
    check("coinc_bar1_old", 128'(bus.bar_vals[1*DATA_W +: DATA_W]), 128'h0000);
    check("coinc_bar2_new", 128'(bus.bar_vals[2*DATA_W +: DATA_W]), 128'h0066);
    pulse_frame();
    check_state("coinc_next");
    check("coinc_bar1_new", 128'(bus.bar_vals[1*DATA_W +: DATA_W]), 128'h0055);

    // Reset mid-packet with csel held high; remaining clocks ignored.
    send_pkt(8'h05, 8'h77, 1'b0);
    bars_snap = bus.bar_vals;
    check("pre_reset_nonzero", 128'(bars_snap != '0), 128'd1);
    bus.spi_csel = 1'b1;
    cyc(4);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        m_shadow  = '0;
        m_live    = '0;
        m_pending = 1'b0;
      end
      bus.spi_mosi = i[0];
      cyc(4);
      bus.spi_clk = 1'b1;
      cyc(4);
      bus.spi_clk = 1'b0;
    end
    cyc(4);
    bus.spi_csel = 1'b0;
    cyc(10);
    check("midreset_no_pulse", 128'(sb.size()), 128'd0);
    check_state("midreset");
    pulse_frame();
    check_state("midreset_frame");

    // Fresh packet after csel low->high is accepted.
    send_pkt(8'h09, 8'h3C, 1'b0);
    check_state("post_reset_wr");
    pulse_frame();
    check_state("post_reset_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_bar_reg_ctrl.md
Name: spi_bar_reg_ctrl

Overview:
- Frame-synchronised configuration controller for the VGA bar-graph display.
- Oversamples the external SPI pins in the CLOCK_50 domain and assembles 16-bit {data, addr} packets into a shadow register file.
- Commits the shadow file to the live bar registers only on a frame-start pulse, so bar lengths never change mid-frame.
- Sits between the GPIO SPI pins and the bar-drawing pixel datapath.

Parameters:
- N_BARS, 15, number of bar registers; valid addresses are 0..N_BARS-1.
- DATA_W, 8, width of each bar register.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2).

Ports:
- CLOCK_50  input  1  system clock; all logic is in this single clock domain.
- reset  input  1  synchronous reset, active-high.
- spi_clk  input  1  asynchronous SPI clock pin.
- spi_csel  input  1  asynchronous chip select; active-high, a packet is framed while it is high.
- spi_mosi  input  1  asynchronous serial data, LSB first.
- frame_start  input  1  one-cycle pulse at the start of vertical blanking, from the timing generator.
- bar_vals  output  N_BARS*DATA_W  live bar registers; bar i is at [i*DATA_W +: DATA_W].
- pending  output  1  high while the shadow file holds writes not yet committed.
- wr_strobe  output  1  one-cycle pulse when a valid packet updates the shadow file.
- err_addr  output  1  one-cycle pulse when a 16-bit packet has addr >= N_BARS.
- err_len  output  1  one-cycle pulse when a packet closes with a bit count other than 16.

Behaviour:
- Input synchronisation:
  - spi_clk, spi_csel and spi_mosi each pass through a SYNC_STAGES flop chain, followed by one history flop for edge detection.
  - Synchroniser stages reset to spi_clk=0, spi_csel=1, spi_mosi=0. Reset value 1 on csel prevents a false open if csel is already high when reset deasserts.
  - Pin-to-edge-detect latency is SYNC_STAGES+1 cycles.
  - Legal SPI timing: each spi_clk phase is at least SYNC_STAGES+1 CLOCK_50 cycles. Faster input is out of spec; the block must not hang, and a misframed packet reports err_len.
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE -> SHIFT on synced csel rising edge: clear the 16-bit shift register and the 5-bit bit counter.
  - SHIFT, on each synced spi_clk rising edge: shift_reg <= {mosi_s, shift_reg[15:1]}. The bit counter increments and saturates at 17.
  - SHIFT -> CHECK on synced csel falling edge. A spi_clk rise in the same cycle as the csel fall is ignored.
  - CHECK lasts exactly one cycle, then returns to IDLE.
    - If bit count != 16: pulse err_len; the shadow file is unchanged.
    - Else, if shift_reg[7:0] >= N_BARS: pulse err_addr; the shadow file is unchanged.
    - Else: shadow[shift_reg[7:0]] <= shift_reg[15:8]; pulse wr_strobe; pending <= 1.
- Commit:
  - On a frame_start cycle with pending=1: bar_vals <= shadow (all bars in one cycle) and pending <= 0.
  - frame_start with pending=0 has no effect.
  - frame_start in the same cycle as a CHECK write: the commit uses the pre-write shadow; the new write lands in shadow, and pending ends the cycle at 1. The write appears at the next frame_start.
  - frame_start pulses in any FSM state.
- Last-write-wins: multiple writes to one address before a commit leave only the final value in shadow.
- Outputs are registered; wr_strobe, err_addr and err_len are never high for more than one cycle, and at most one of them pulses per packet.
- Reset, including mid-packet:
  - State goes to IDLE; the partial packet is discarded with no error pulse.
  - shadow, bar_vals, the bit counter and shift_reg go to 0; pending, wr_strobe, err_addr and err_len go to 0.
  - The first packet accepted after reset requires a fresh csel rising edge.

Test Plan:
- Reset, then packet addr=0x03, data=0xA5 (LSB-first bits of 0xA503) -> wr_strobe pulses once and pending=1. bar_vals stays 0 until frame_start, then bar 3=0xA5 and pending=0.
- Packet addr=0x0F (N_BARS=15), data=0x11 -> err_addr pulses; shadow is unchanged; pending stays 0; the next frame_start leaves bar_vals unchanged.
- Packet with 12 clocks, then one with 20 clocks -> err_len pulses for each; no wr_strobe; shadow is unchanged.
- Writes of 0x10 then 0x20 to addr 7, then frame_start -> bar 7=0x20 and all other bars are unchanged.
- frame_start coincident with the CHECK cycle of write addr=1, data=0x55 -> that commit leaves bar 1 at its old value and pending=1; the next frame_start sets bar 1=0x55.
- Reset asserted after 8 bits of a packet while csel stays high -> no pulses, outputs are 0, and remaining clocks are ignored. The next full packet after csel low->high is accepted normally.
